fir_xifu_wb: RTL and testbench

Write-back stage of the FIR XIFU pipeline, directly downstream of the execute stage. Consumes the registered EX/WB payload, collects load data from the CV32E40X LSU through the X-interface memory-result channel, and commits results to the XIFU register file. Returns exactly one X-interface result per offloaded instruction to the core, including the post-incremented address for load/store. Drives the forwarding bus used by EX for back-to-back address updates.

---
 rtl/fir_xifu_wb.sv | 230 +++++++++++++++++++++++
 tb/tb_fir_xifu_wb.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_xifu_wb.sv
// fir_xifu_wb: write-back stage of the FIR XIFU pipeline.
// Gathers LSU load data, writes the XIFU register file and returns one
// X-interface result per offloaded instruction. It also drives the forwarding
// bus that EX uses for back-to-back address updates.
// The X-interface channels are flattened into discrete ports.
// Optional feature macro: FIR_XIFU_WB_MEM_ERR_EN turns a memory response with
// err=1 into a load/store fault on the result.

package fir_xifu_pkg;
  localparam int unsigned X_ID_W = 4;

  typedef enum logic [1:0] {
    INSTR_INVALID  = 2'd0,
    INSTR_XFIRLW   = 2'd1,
    INSTR_XFIRSW   = 2'd2,
    INSTR_XFIRDOTP = 2'd3
  } instr_e;

  typedef struct packed {
    logic [31:0]       result;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [4:0]        rd;
    instr_e            instr;
    logic [X_ID_W-1:0] id;
  } ex2wb_t;

  typedef struct packed {
    logic        we;
    logic [4:0]  rd;
    logic [31:0] wdata;
  } wb2regfile_t;

  typedef struct packed {
    logic        we;
    logic [4:0]  rd;
    logic [31:0] result;
  } wb_fwd_t;

  // Exception causes as encoded by the CV32E40X core
  localparam logic [5:0] EXC_CAUSE_LOAD_FAULT  = 6'h05;
  localparam logic [5:0] EXC_CAUSE_STORE_FAULT = 6'h07;
endpackage

module fir_xifu_wb
  import fir_xifu_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clear_i,
  // memory-result channel from the LSU
  input  logic              xif_mem_result_valid_i,
  input  logic [X_ID_W-1:0] xif_mem_result_id_i,
  input  logic [31:0]       xif_mem_result_rdata_i,
  input  logic              xif_mem_result_err_i,
  // result channel toward the core
  output logic              xif_result_valid_o,
  input  logic              xif_result_ready_i,
  output logic [X_ID_W-1:0] xif_result_id_o,
  output logic [31:0]       xif_result_data_o,
  output logic [4:0]        xif_result_rd_o,
  output logic              xif_result_we_o,
  output logic              xif_result_exc_o,
  output logic [5:0]        xif_result_exccode_o,
  // pipeline side
  input  ex2wb_t            ex2wb_i,
  output wb2regfile_t       wb2regfile_o,
  output wb_fwd_t           wb_fwd_o,
  output logic              ready_o
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_MEM = 2'd1,
    WAIT_RES = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic is_lw, is_sw, is_dotp, is_bubble;
  logic mem_hit, mem_err, res_exc;
  logic res_valid, retire, rf_we;
  logic [31:0] rf_wdata;
  logic drop_q;

  assign is_lw     = (ex2wb_i.instr == INSTR_XFIRLW);
  assign is_sw     = (ex2wb_i.instr == INSTR_XFIRSW);
  assign is_dotp   = (ex2wb_i.instr == INSTR_XFIRDOTP);
  assign is_bubble = (ex2wb_i.instr == INSTR_INVALID);

  // A memory response only counts while a load is waiting for it and its id matches
  assign mem_hit = xif_mem_result_valid_i && !clear_i
                   && (xif_mem_result_id_i == ex2wb_i.id)
                   && (((state_q == IDLE) && is_lw) || (state_q == WAIT_MEM));

`ifdef FIR_XIFU_WB_MEM_ERR_EN
  logic err_q;

  // Error flag of the accepted memory response, dropped when the instruction leaves WB
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                 err_q <= 1'b0;
    else if (clear_i || retire)  err_q <= 1'b0;
    else if (mem_hit)            err_q <= xif_mem_result_err_i;
  end

  assign mem_err = xif_mem_result_err_i;
  assign res_exc = (state_q == WAIT_RES) && err_q;
`else
  logic unused_err;
  assign unused_err = xif_mem_result_err_i;
  assign mem_err    = 1'b0;
  assign res_exc    = 1'b0;
`endif

  logic [4:0] unused_rs2;
  assign unused_rs2 = ex2wb_i.rs2;

  // Next state, handshake and regfile write; valid/write are combinational so
  // SW/DOTP complete in a single WB cycle
  always_comb begin
    state_d   = state_q;
    res_valid = 1'b0;
    retire    = 1'b0;
    ready_o   = 1'b0;
    rf_we     = 1'b0;
    rf_wdata  = 32'h0;
    if (clear_i) begin
      state_d = IDLE;
      ready_o = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (is_bubble) begin
            ready_o = 1'b1;
          end else if (is_lw) begin
            if (mem_hit) begin
              rf_we    = !mem_err;
              rf_wdata = xif_mem_result_rdata_i;
              state_d  = WAIT_RES;
            end else begin
              state_d  = WAIT_MEM;
            end
          end else begin
            res_valid = 1'b1;
            if (xif_result_ready_i) begin
              retire   = 1'b1;
              ready_o  = 1'b1;
              rf_we    = is_dotp;
              rf_wdata = ex2wb_i.result;
            end else begin
              state_d  = WAIT_RES;
            end
          end
        end
        WAIT_MEM: begin
          if (mem_hit) begin
            rf_we    = is_lw && !mem_err;
            rf_wdata = xif_mem_result_rdata_i;
            state_d  = WAIT_RES;
          end
        end
        WAIT_RES: begin
          res_valid = 1'b1;
          if (xif_result_ready_i) begin
            retire   = 1'b1;
            ready_o  = 1'b1;
            rf_we    = is_dotp;
            rf_wdata = ex2wb_i.result;
            state_d  = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Remembers a load abandoned by a flush so its late response is expected, not an error
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                     drop_q <= 1'b0;
    else if (clear_i)                drop_q <= (state_q == WAIT_MEM) || ((state_q == IDLE) && is_lw);
    else if (xif_mem_result_valid_i) drop_q <= 1'b0;
  end

  // Result payload; zero whenever no result is offered
  always_comb begin
    xif_result_valid_o   = res_valid;
    xif_result_id_o      = '0;
    xif_result_data_o    = 32'h0;
    xif_result_rd_o      = 5'h0;
    xif_result_we_o      = 1'b0;
    xif_result_exc_o     = 1'b0;
    xif_result_exccode_o = 6'h0;
    if (res_valid) begin
      xif_result_id_o   = ex2wb_i.id;
      xif_result_data_o = ex2wb_i.result;
      xif_result_rd_o   = ex2wb_i.rs1;
      xif_result_we_o   = (is_lw || is_sw) && !res_exc;
      xif_result_exc_o  = res_exc;
      if (res_exc)
        xif_result_exccode_o = is_sw ? EXC_CAUSE_STORE_FAULT : EXC_CAUSE_LOAD_FAULT;
    end
  end

  // Regfile write port and EX forwarding bus
  always_comb begin
    wb2regfile_o = '0;
    wb_fwd_o     = '0;
    if (rf_we) begin
      wb2regfile_o.we    = 1'b1;
      wb2regfile_o.rd    = ex2wb_i.rd;
      wb2regfile_o.wdata = rf_wdata;
    end
    if (!clear_i && (is_lw || is_sw)) begin
      wb_fwd_o.we     = 1'b1;
      wb_fwd_o.rd     = ex2wb_i.rs1;
      wb_fwd_o.result = ex2wb_i.result;
    end
  end

  // Memory responses are only legal for a waiting load or a flushed one
  a_mem_result_expected: assert property (@(posedge clk_i) disable iff (!rst_ni)
    xif_mem_result_valid_i |-> (mem_hit || drop_q || clear_i));

endmodule

// File: tb/tb_fir_xifu_wb.sv
// Testbench for fir_xifu_wb: directed vectors with literal expectations plus a
// per-cycle compare against a transaction-level model of the WB stage.
`timescale 1ns/1ps

module tb_fir_xifu_wb;
  import fir_xifu_pkg::*;

`ifdef FIR_XIFU_WB_MEM_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic              clk_i = 1'b0;
  logic              rst_ni;
  logic              clear_i;
  logic              mem_valid;
  logic [X_ID_W-1:0] mem_id;
  logic [31:0]       mem_rdata;
  logic              mem_err;
  logic              res_valid;
  logic              res_ready;
  logic [X_ID_W-1:0] res_id;
  logic [31:0]       res_data;
  logic [4:0]        res_rd;
  logic              res_we;
  logic              res_exc;
  logic [5:0]        res_exccode;
  ex2wb_t            ex;
  wb2regfile_t       rf;
  wb_fwd_t           fwd;
  logic              ready;

  int n_checks = 0;
  int n_pass   = 0;
  int hs_cnt   = 0;
  int wr_cnt   = 0;

  always #5 clk_i = ~clk_i;

  fir_xifu_wb dut (
    .clk_i                  (clk_i),
    .rst_ni                 (rst_ni),
    .clear_i                (clear_i),
    .xif_mem_result_valid_i (mem_valid),
    .xif_mem_result_id_i    (mem_id),
    .xif_mem_result_rdata_i (mem_rdata),
    .xif_mem_result_err_i   (mem_err),
    .xif_result_valid_o     (res_valid),
    .xif_result_ready_i     (res_ready),
    .xif_result_id_o        (res_id),
    .xif_result_data_o      (res_data),
    .xif_result_rd_o        (res_rd),
    .xif_result_we_o        (res_we),
    .xif_result_exc_o       (res_exc),
    .xif_result_exccode_o   (res_exccode),
    .ex2wb_i                (ex),
    .wb2regfile_o           (rf),
    .wb_fwd_o               (fwd),
    .ready_o                (ready)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- transaction-level model ----------------
  // m_got: the load in WB already has its data; m_err: that data carried err
  bit m_got, m_err;

  typedef struct packed {
    logic              valid;
    logic [X_ID_W-1:0] id;
    logic [31:0]       data;
    logic [4:0]        rd;
    logic              we;
    logic              exc;
    logic [5:0]        exccode;
    logic              rf_we;
    logic [4:0]        rf_rd;
    logic [31:0]       rf_wdata;
    logic              fwd_we;
    logic [4:0]        fwd_rd;
    logic [31:0]       fwd_res;
    logic              ready;
  } exp_t;

  function automatic exp_t expect_now();
    exp_t e = '0;
    bit   fault;
    if (clear_i) begin
      e.ready = 1'b1;
      return e;
    end
    if (ex.instr == INSTR_INVALID) begin
      e.ready = 1'b1;
      return e;
    end
    if (ex.instr == INSTR_XFIRLW) begin
      if (!m_got && mem_valid && mem_id == ex.id && !(ERR_EN && mem_err)) begin
        e.rf_we = 1'b1; e.rf_rd = ex.rd; e.rf_wdata = mem_rdata;
      end
      e.valid = m_got;
    end else begin
      e.valid = 1'b1;
      if (ex.instr == INSTR_XFIRDOTP && res_ready) begin
        e.rf_we = 1'b1; e.rf_rd = ex.rd; e.rf_wdata = ex.result;
      end
    end
    fault = ERR_EN && m_err;
    if (e.valid) begin
      e.id   = ex.id;
      e.data = ex.result;
      e.rd   = ex.rs1;
      e.we   = (ex.instr != INSTR_XFIRDOTP) && !fault;
      e.exc  = fault;
      e.exccode = fault ? EXC_CAUSE_LOAD_FAULT : 6'h0;
      e.ready = res_ready;
    end
    if (ex.instr == INSTR_XFIRLW || ex.instr == INSTR_XFIRSW) begin
      e.fwd_we = 1'b1; e.fwd_rd = ex.rs1; e.fwd_res = ex.result;
    end
    return e;
  endfunction

  // Model update on each clock edge, from the inputs of the finishing cycle
  always @(posedge clk_i or negedge rst_ni) begin
    exp_t e;
    if (!rst_ni) begin
      m_got = 1'b0; m_err = 1'b0;
    end else begin
      e = expect_now();
      if (clear_i || (e.valid && res_ready)) begin
        m_got = 1'b0; m_err = 1'b0;
      end else if (ex.instr == INSTR_XFIRLW && !m_got && mem_valid && mem_id == ex.id) begin
        m_got = 1'b1; m_err = mem_err;
      end
    end
  end

  // Per-cycle compare against the model
  always @(negedge clk_i) begin
    exp_t e;
    if (rst_ni) begin
      e = expect_now();
      chk("result_bus", {14'h0, res_valid, res_id, res_data, res_rd, res_we, res_exc, res_exccode},
                        {14'h0, e.valid, e.id, e.data, e.rd, e.we, e.exc, e.exccode});
      chk("regfile_bus", {26'h0, rf}, {26'h0, e.rf_we, e.rf_rd, e.rf_wdata});
      chk("fwd_bus", {26'h0, fwd}, {26'h0, e.fwd_we, e.fwd_rd, e.fwd_res});
      chk("ready", {63'h0, ready}, {63'h0, e.ready});
    end
  end

  // Handshake and regfile-write counters
  always @(posedge clk_i) begin
    if (res_valid && res_ready) hs_cnt++;
    if (rf.we) wr_cnt++;
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_ex(input instr_e ins, input logic [X_ID_W-1:0] id, input logic [4:0] rs1,
                        input logic [4:0] rd, input logic [31:0] result);
    ex.instr = ins; ex.id = id; ex.rs1 = rs1; ex.rs2 = 5'd0; ex.rd = rd; ex.result = result;
  endtask

  task automatic set_mem(input logic v, input logic [X_ID_W-1:0] id, input logic [31:0] d, input logic e);
    mem_valid = v; mem_id = id; mem_rdata = d; mem_err = e;
  endtask

  initial begin
    rst_ni = 1'b0; clear_i = 1'b0; res_ready = 1'b1;
    set_ex(INSTR_INVALID, 0, 0, 0, 0);
    set_mem(0, 0, 0, 0);
    repeat (2) @(posedge clk_i);
    #3;
    chk("rst_ready", ready, 1);
    chk("rst_valid", res_valid, 0);
    chk("rst_rf_we", rf.we, 0);
    chk("rst_fwd_we", fwd.we, 0);
    #1 rst_ni = 1'b1;

    // DOTP retiring in one cycle
    cyc(); set_ex(INSTR_XFIRDOTP, 4'd1, 5'd1, 5'd3, 32'h0000_1234); #2;
    chk("dotp_rf", {26'h0, rf}, {26'h0, 1'b1, 5'd3, 32'h0000_1234});
    chk("dotp_valid", res_valid, 1);
    chk("dotp_we", res_we, 0);
    chk("dotp_ready", ready, 1);

    // back-to-back SW then DOTP
    cyc(); set_ex(INSTR_XFIRSW, 4'd2, 5'd9, 5'd0, 32'h0000_3000); #2;
    chk("b2b_sw_data", res_data, 32'h3000);
    chk("b2b_sw_ready", ready, 1);
    cyc(); set_ex(INSTR_XFIRDOTP, 4'd3, 5'd2, 5'd4, 32'h0000_ABCD); #2;
    chk("b2b_dotp_rf", {26'h0, rf}, {26'h0, 1'b1, 5'd4, 32'h0000_ABCD});

    // LW with data three cycles later
    cyc(); set_ex(INSTR_XFIRLW, 4'd2, 5'd10, 5'd5, 32'h0000_1004); #2;
    chk("lw_fwd", {26'h0, fwd}, {26'h0, 1'b1, 5'd10, 32'h0000_1004});
    chk("lw_wait_valid", res_valid, 0);
    chk("lw_wait_ready", ready, 0);
    cyc(); cyc();
    cyc(); set_mem(1, 4'd2, 32'hDEAD_BEEF, 0); #2;
    chk("lw_rf", {26'h0, rf}, {26'h0, 1'b1, 5'd5, 32'hDEAD_BEEF});
    chk("lw_mem_valid", res_valid, 0);
    cyc(); set_mem(0, 0, 0, 0); #2;
    chk("lw_res", {36'h0, res_valid, res_rd, res_data, res_we}, {36'h0, 1'b1, 5'd10, 32'h0000_1004, 1'b1});
    chk("lw_res_fwd_we", fwd.we, 1);
    chk("lw_res_rf_we", rf.we, 0);

    // SW stalled four cycles on result_ready
    cyc(); set_ex(INSTR_XFIRSW, 4'd3, 5'd7, 5'd0, 32'h0000_2000); res_ready = 1'b0; hs_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      #2;
      chk("sw_stall", {27'h0, res_valid, res_data, ready}, {27'h0, 1'b1, 32'h0000_2000, 1'b0});
      cyc();
    end
    res_ready = 1'b1; #2;
    chk("sw_hs_ready", ready, 1);
    cyc(); set_ex(INSTR_INVALID, 0, 0, 0, 0); #2;
    chk("sw_hs_count", hs_cnt, 1);
    chk("sw_after_valid", res_valid, 0);

    // DOTP stalled two cycles: one write, in the handshake cycle
    cyc(); set_ex(INSTR_XFIRDOTP, 4'd4, 5'd3, 5'd6, 32'h0000_55AA); res_ready = 1'b0; wr_cnt = 0;
    #2; chk("dotp_stall_we0", rf.we, 0);
    cyc(); #2; chk("dotp_stall_we1", rf.we, 0);
    cyc(); res_ready = 1'b1; #2; chk("dotp_hs_we", rf.we, 1);
    cyc(); set_ex(INSTR_INVALID, 0, 0, 0, 0); #2;
    chk("dotp_wr_count", wr_cnt, 1);

    // clear during WAIT_MEM, then a late matching response
    cyc(); set_ex(INSTR_XFIRLW, 4'd4, 5'd11, 5'd7, 32'h0000_2008);
    cyc(); cyc(); clear_i = 1'b1; set_ex(INSTR_INVALID, 0, 0, 0, 0); #2;
    chk("clr_ready", ready, 1);
    chk("clr_valid", res_valid, 0);
    cyc(); clear_i = 1'b0; set_mem(1, 4'd4, 32'h1234_5678, 0); wr_cnt = 0; #2;
    chk("clr_late_rf_we", rf.we, 0);
    chk("clr_late_valid", res_valid, 0);
    chk("clr_late_ready", ready, 1);
    cyc(); set_mem(0, 0, 0, 0);

    // LW with same-cycle data proves the FSM is back in IDLE
    set_ex(INSTR_XFIRLW, 4'd5, 5'd12, 5'd8, 32'h0000_200C); set_mem(1, 4'd5, 32'hCAFE_F00D, 0); #2;
    chk("lw2_rf", {26'h0, rf}, {26'h0, 1'b1, 5'd8, 32'hCAFE_F00D});
    chk("lw2_ready0", ready, 0);
    cyc(); set_mem(0, 0, 0, 0); #2;
    chk("lw2_res", {36'h0, res_valid, res_rd, res_data, res_we}, {36'h0, 1'b1, 5'd12, 32'h0000_200C, 1'b1});
    chk("lw2_ready1", ready, 1);
    chk("clr_no_stray_write", wr_cnt, 1);

    // LW whose response carries err
    cyc(); set_ex(INSTR_XFIRLW, 4'd6, 5'd13, 5'd9, 32'h0000_2010); set_mem(1, 4'd6, 32'h0BAD_BEEF, 1); #2;
    chk("err_rf_we", rf.we, ERR_EN ? 1'b0 : 1'b1);
    cyc(); set_mem(0, 0, 0, 0); #2;
    chk("err_valid", res_valid, 1);
    chk("err_exc", res_exc, ERR_EN ? 1'b1 : 1'b0);
    chk("err_exccode", res_exccode, ERR_EN ? EXC_CAUSE_LOAD_FAULT : 6'h0);
    chk("err_we", res_we, ERR_EN ? 1'b0 : 1'b1);
    cyc(); set_ex(INSTR_INVALID, 0, 0, 0, 0);
    repeat (3) cyc();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
